// File: rtl/sv_serial_pkg.sv
// Shared types and helpers for the state-vector serializer: FSM state, index
// width calculation, and real/imag splitting of packed complex amplitudes.
package sv_serial_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sv_state_e;

    // Index width for a frame of n amplitudes; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Real half (upper bits) of a w-bit packed amplitude, sign-extended to 32 bits.
    function automatic logic signed [31:0] amp_re(input logic [63:0] amp, input int w);
        logic signed [31:0] r;
        int half;
        half = w / 2;
        r    = '0;
        for (int b = 0; b < 32; b++) begin
            r[b] = (b < half) ? amp[half + b] : amp[w - 1];
        end
        return r;
    endfunction

    // Imaginary half (lower bits) of a w-bit packed amplitude, sign-extended to 32 bits.
    function automatic logic signed [31:0] amp_im(input logic [63:0] amp, input int w);
        logic signed [31:0] r;
        int half;
        half = w / 2;
        r    = '0;
        for (int b = 0; b < 32; b++) begin
            r[b] = (b < half) ? amp[b] : amp[half - 1];
        end
        return r;
    endfunction

endpackage

// File: rtl/sv_frame_buffer.sv
// Frame-wide amplitude register array: whole-frame parallel write, single
// indexed read port used as the serial output mux.
module sv_frame_buffer
    import sv_serial_pkg::*;
#(
    parameter int sample_size    = 4,
    parameter int complexnum_bit = 24,
    parameter int IDX_W          = idx_width(sample_size)
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_we,
    input  logic signed [complexnum_bit-1:0]  i_wdata [0:sample_size-1],
    input  logic        [IDX_W-1:0]           i_raddr,
    output logic signed [complexnum_bit-1:0]  o_rdata
);

    logic signed [complexnum_bit-1:0] r_mem [0:sample_size-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < sample_size; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/state_vector_serializer.sv
// Streams a parallel frame of complex amplitudes out one beat at a time with
// basis-state index and last flag; supports zero-bubble back-to-back frames.
module state_vector_serializer
    import sv_serial_pkg::*;
#(
    parameter int sample_size    = 4,
    parameter int complexnum_bit = 24
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         load_valid,
    output logic                                         load_ready,
    input  logic signed [complexnum_bit-1:0]             in [0:sample_size-1],
    input  logic                                         abort,
    output logic signed [complexnum_bit-1:0]             out_data,
    output logic        [idx_width(sample_size)-1:0]     out_index,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         out_last,
    output logic                                         busy
);

    localparam int               IDX_W    = idx_width(sample_size);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(sample_size - 1);

    sv_state_e                        r_state;
    sv_state_e                        w_state_nxt;
    logic        [IDX_W-1:0]          r_index;
    logic        [IDX_W-1:0]          w_index_nxt;
    logic                             w_is_last;
    logic                             w_load_fire;
    logic                             w_out_fire;
    logic signed [complexnum_bit-1:0] w_buf_data;

    assign w_is_last   = (r_index == LAST_IDX);
    assign w_load_fire = load_valid && load_ready;
    assign w_out_fire  = out_valid && out_ready;

    sv_frame_buffer #(
        .sample_size    (sample_size),
        .complexnum_bit (complexnum_bit),
        .IDX_W          (IDX_W)
    ) u_frame_buffer (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_we    (w_load_fire && !abort),
        .i_wdata (in),
        .i_raddr (r_index),
        .o_rdata (w_buf_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
        end
    end

    // Abort outranks load, load outranks the plain last-beat return to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        if (abort) begin
            w_state_nxt = IDLE;
            w_index_nxt = '0;
        end else if (w_load_fire) begin
            w_state_nxt = STREAM;
            w_index_nxt = '0;
        end else if (w_out_fire) begin
            if (w_is_last) begin
                w_state_nxt = IDLE;
                w_index_nxt = '0;
            end else begin
                w_index_nxt = r_index + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid  = (r_state == STREAM);
        busy       = (r_state == STREAM);
        out_index  = r_index;
        out_last   = (r_state == STREAM) && w_is_last;
        out_data   = (r_state == STREAM) ? w_buf_data : '0;
        load_ready = !abort &&
                     ((r_state == IDLE) || ((r_state == STREAM) && out_ready && w_is_last));
    end

endmodule

// File: tb/tb_state_vector_serializer.sv
// Bench for state_vector_serializer: table vectors, directed corner sequences
// and random traffic checked against a queue-of-pending-beats reference model.
module tb_state_vector_serializer;
    import sv_serial_pkg::*;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int IW = idx_width(N);

    logic                 clk;
    logic                 rst;
    logic                 load_valid;
    logic                 load_ready;
    logic signed [W-1:0]  tb_in [0:N-1];
    logic                 abort;
    logic signed [W-1:0]  out_data;
    logic        [IW-1:0] out_index;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;

    state_vector_serializer #(
        .sample_size    (N),
        .complexnum_bit (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .in         (tb_in),
        .abort      (abort),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the beats still owed to the consumer, in delivery order.
    typedef struct {
        int data;
        int idx;
    } beat_t;
    beat_t q[$];

    bit m_lv, m_lr, m_ab, m_fire_out;

    typedef struct {
        bit lv;
        bit rdy;
        bit ab;
        bit e_valid;
        int e_idx;
        bit e_last;
        bit e_lr;
        int e_data;
    } vec_t;
    vec_t vecs [0:5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_frame(input int a0, input int a1, input int a2, input int a3);
        tb_in[0] = W'(a0);
        tb_in[1] = W'(a1);
        tb_in[2] = W'(a2);
        tb_in[3] = W'(a3);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) tb_in[i] = W'($urandom);
    endtask

    // Drive inputs just after the falling edge, then compare against the model.
    task automatic drive_check(input bit lv, input bit rdy, input bit ab);
        bit e_valid, e_last;
        int e_idx;
        load_valid = lv;
        out_ready  = rdy;
        abort      = ab;
        #1;
        e_valid = (q.size() > 0);
        e_idx   = e_valid ? q[0].idx : 0;
        e_last  = e_valid && (e_idx == N - 1);
        m_lr    = !ab && (!e_valid || (rdy && e_last));
        m_lv    = lv;
        m_ab    = ab;
        m_fire_out = e_valid && rdy;
        chk("out_valid", int'(out_valid), int'(e_valid));
        chk("busy", int'(busy), int'(e_valid));
        chk("load_ready", int'(load_ready), int'(m_lr));
        chk("out_last", int'(out_last), int'(e_last));
        chk("out_index", int'(out_index), e_idx);
        if (e_valid) chk("out_data", int'(out_data), q[0].data);
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_ab) begin
            q.delete();
        end else begin
            if (m_fire_out) void'(q.pop_front());
            if (m_lv && m_lr) begin
                for (int i = 0; i < N; i++) q.push_back('{int'(tb_in[i]), i});
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input bit lv, input bit rdy, input bit ab);
        drive_check(lv, rdy, ab);
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        out_ready  = 1'b0;
        abort      = 1'b0;
        set_frame(0, 0, 0, 0);
        #1;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst out_last", int'(out_last), 0);
        chk("rst out_index", int'(out_index), 0);
        chk("rst out_data", int'(out_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic frame, consumer always ready
        vecs[0] = '{1, 1, 0, 0, 0, 0, 1, 0};
        vecs[1] = '{0, 1, 0, 1, 0, 0, 0, 100};
        vecs[2] = '{0, 1, 0, 1, 1, 0, 0, -200};
        vecs[3] = '{0, 1, 0, 1, 2, 0, 0, 300};
        vecs[4] = '{0, 1, 0, 1, 3, 1, 1, -400};
        vecs[5] = '{0, 1, 0, 0, 0, 0, 1, 0};
        set_frame(100, -200, 300, -400);
        for (int v = 0; v < 6; v++) begin
            drive_check(vecs[v].lv, vecs[v].rdy, vecs[v].ab);
            chk("tbl out_valid", int'(out_valid), int'(vecs[v].e_valid));
            chk("tbl out_index", int'(out_index), vecs[v].e_idx);
            chk("tbl out_last", int'(out_last), int'(vecs[v].e_last));
            chk("tbl load_ready", int'(load_ready), int'(vecs[v].e_lr));
            if (vecs[v].e_valid) chk("tbl out_data", int'(out_data), vecs[v].e_data);
            advance();
        end

        // Stalling consumer: each beat must hold until accepted
        step(1, 1, 0);
        begin
            bit pat [0:11] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1};
            for (int i = 0; i < 12; i++) step(0, pat[i], 0);
        end
        chk("stall drained", int'(out_valid), 0);

        // Back-to-back reload on the last beat
        set_frame(100, -200, 300, -400);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        set_frame(5, 6, 7, 8);
        drive_check(1, 1, 0);
        chk("b2b load_ready", int'(load_ready), 1);
        advance();
        drive_check(0, 1, 0);
        chk("b2b no bubble valid", int'(out_valid), 1);
        chk("b2b first idx", int'(out_index), 0);
        chk("b2b first data", int'(out_data), 5);
        advance();
        for (int i = 0; i < 4; i++) step(0, 1, 0);

        // Load offered mid-frame is ignored
        set_frame(100, -200, 300, -400);
        step(1, 1, 0);
        step(0, 1, 0);
        set_frame(11, 22, 33, 44);
        drive_check(1, 1, 0);
        chk("midframe load_ready", int'(load_ready), 0);
        advance();
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        step(0, 1, 0);

        // Abort at idx2, then restart
        set_frame(100, -200, 300, -400);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        drive_check(1, 1, 1);
        chk("abort idx", int'(out_index), 2);
        chk("abort blocks load", int'(load_ready), 0);
        advance();
        drive_check(0, 1, 0);
        chk("post-abort valid", int'(out_valid), 0);
        chk("post-abort load_ready", int'(load_ready), 1);
        advance();
        set_frame(9, -9, 90, -90);
        step(1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);

        // Async reset mid-frame
        set_frame(100, -200, 300, -400);
        step(1, 1, 0);
        step(0, 1, 0);
        drive_check(0, 1, 0);
        rst = 1'b0;
        #1;
        chk("async rst valid", int'(out_valid), 0);
        chk("async rst busy", int'(busy), 0);
        chk("async rst index", int'(out_index), 0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_frame(-1, 2, -3, 4);
        step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rand_frame();
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
